// File: rtl/ste_key_pkg.sv
// Shared types and defaults for the front-panel key event decoder.
package ste_key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  localparam int unsigned CNT_W_DEF = 12;

endpackage

// File: rtl/ste_tick_timer.sv
// Tick-driven down-counter with load; expire flags a tick arriving at count <= 1.
module ste_tick_timer
  import ste_key_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = tick_i && (cnt_q <= CNT_W'(1));
  assign cnt_o    = cnt_q;

  // Counter parks at 1 on expiry; the owner reloads it when it acts on expire.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ste_key_event.sv
// Debounced key to press/release/short/long/repeat pulse decoder with held level.
module ste_key_event
  import ste_key_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] long_thr_i,
  input  logic [CNT_W-1:0] rep_per_i,
  output logic             press_o,
  output logic             release_o,
  output logic             short_o,
  output logic             long_o,
  output logic             rep_o,
  output logic             held_o
);

  key_state_t state_q, state_d;

  logic press_q, press_d;
  logic release_q, release_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic held_q, held_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_tick;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_expire;

  // A zero count in REPEAT means repeat was disabled at load, so ticks are ignored there.
  assign tmr_tick = tick_i && key_i &&
                    ((state_q == HOLD) || ((state_q == REPEAT) && (tmr_cnt != '0)));

  ste_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tick_i     (tmr_tick),
    .cnt_o      (tmr_cnt),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    short_d      = 1'b0;
    long_d       = 1'b0;
    rep_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = long_thr_i;

    case (state_q)
      IDLE: begin
        if (key_i) begin
          press_d      = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = long_thr_i;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (!key_i) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          state_d   = IDLE;
        end else if (tmr_expire) begin
          long_d       = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = rep_per_i;
          state_d      = REPEAT;
        end
      end
      REPEAT: begin
        if (!key_i) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (tmr_expire) begin
          rep_d        = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = rep_per_i;
        end
      end
      default: state_d = IDLE;
    endcase

    held_d = (state_d == HOLD) || (state_d == REPEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign short_o   = short_q;
  assign long_o    = long_q;
  assign rep_o     = rep_q;
  assign held_o    = held_q;

endmodule
